id_stage_fwd: RTL

//  Decode stage for the 5-stage MIPS pipeline; successor to the fixed-wiring decoder.

---
 rtl/id_stage_fwd.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: MIPS decode stage with N-source operand forwarding, load-use interlock and a saturating stall counter
module id_stage_fwd #(
  parameter int FWD_N     = 3,
  parameter int CNT_WD    = 32,
  parameter int RF_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_allowin,
  output logic                ds_allowin,
  input  logic                fs_to_ds_valid,
  input  logic [63:0]         fs_to_ds_bus,
  output logic                ds_to_es_valid,
  output logic [135:0]        ds_to_es_bus,
  output logic [32:0]         br_bus,
  input  logic [37:0]         ws_to_rf_bus,
  input  logic [FWD_N-1:0]    fwd_valid,
  input  logic [FWD_N-1:0]    fwd_we,
  input  logic [5*FWD_N-1:0]  fwd_dest,
  input  logic [FWD_N-1:0]    fwd_ready,
  input  logic [32*FWD_N-1:0] fwd_data,
  output logic [CNT_WD-1:0]   stall_cnt
);
  logic              r_ds_valid;
  logic [31:0]       r_inst;
  logic [31:0]       r_pc;
  logic [31:0]       r_rf [32];
  logic [CNT_WD-1:0] r_stall_cnt;
  logic        w_ws_we;
  logic [4:0]  w_ws_addr;
  logic [31:0] w_ws_data;
  logic [31:0] w_fs_pc;
  logic [5:0]  w_op, w_func;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [15:0] w_imm;
  logic [25:0] w_jidx;
  logic w_addu, w_subu, w_slt, w_sltu, w_and, w_or, w_xor, w_nor, w_sll, w_srl, w_sra;
  logic w_addiu, w_lui, w_lw, w_sw, w_beq, w_bne, w_jal, w_jr;
  logic w_r_alu, w_add, w_gr_we, w_mem_we, w_load_op;
  logic w_src1_is_sa, w_src1_is_pc, w_src2_is_imm, w_src2_is_8;
  logic [11:0] w_alu_op;
  logic w_rs_use, w_rt_use, w_ready_go, w_eq, w_br_taken;
  logic [32:0] w_rs_sel, w_rt_sel;
  logic [31:0] w_rs_val, w_rt_val, w_br_target;

  assign {w_ws_we, w_ws_addr, w_ws_data} = ws_to_rf_bus;
  assign w_fs_pc = fs_to_ds_bus[31:0];
  assign w_op    = r_inst[31:26];
  assign w_rs    = r_inst[25:21];
  assign w_rt    = r_inst[20:16];
  assign w_rd    = r_inst[15:11];
  assign w_func  = r_inst[5:0];
  assign w_imm   = r_inst[15:0];
  assign w_jidx  = r_inst[25:0];

  assign w_addu  = w_op == 6'h00 && w_func == 6'h21;
  assign w_subu  = w_op == 6'h00 && w_func == 6'h23;
  assign w_slt   = w_op == 6'h00 && w_func == 6'h2a;
  assign w_sltu  = w_op == 6'h00 && w_func == 6'h2b;
  assign w_and   = w_op == 6'h00 && w_func == 6'h24;
  assign w_or    = w_op == 6'h00 && w_func == 6'h25;
  assign w_xor   = w_op == 6'h00 && w_func == 6'h26;
  assign w_nor   = w_op == 6'h00 && w_func == 6'h27;
  assign w_sll   = w_op == 6'h00 && w_func == 6'h00;
  assign w_srl   = w_op == 6'h00 && w_func == 6'h02;
  assign w_sra   = w_op == 6'h00 && w_func == 6'h03;
  assign w_jr    = w_op == 6'h00 && w_func == 6'h08;
  assign w_addiu = w_op == 6'h09;
  assign w_lui   = w_op == 6'h0f;
  assign w_lw    = w_op == 6'h23;
  assign w_sw    = w_op == 6'h2b;
  assign w_beq   = w_op == 6'h04;
  assign w_bne   = w_op == 6'h05;
  assign w_jal   = w_op == 6'h03;

  assign w_r_alu       = w_addu | w_subu | w_slt | w_sltu | w_and | w_or | w_xor | w_nor | w_sll | w_srl | w_sra;
  assign w_add         = w_addu | w_addiu | w_lw | w_sw | w_jal;
  assign w_alu_op      = {w_lui, w_sra, w_srl, w_sll, w_xor, w_or, w_nor, w_and, w_sltu, w_slt, w_subu, w_add};
  assign w_load_op     = w_lw;
  assign w_src1_is_sa  = w_sll | w_srl | w_sra;
  assign w_src1_is_pc  = w_jal;
  assign w_src2_is_imm = w_addiu | w_lui | w_lw | w_sw;
  assign w_src2_is_8   = w_jal;
  assign w_gr_we       = w_r_alu | w_addiu | w_lui | w_lw | w_jal;
  assign w_mem_we      = w_sw;
  // non-writing instructions carry dest 0 so EX never sees a stale register number
  assign w_dest        = !w_gr_we ? 5'd0 : w_jal ? 5'd31 : w_r_alu ? w_rd : w_rt;
  assign w_rs_use      = !(w_sll | w_srl | w_sra | w_lui | w_jal);
  assign w_rt_use      = w_r_alu | w_sw | w_beq | w_bne;

  // {ready, value} for one source register: youngest matching forward source wins, else regfile
  function automatic logic [32:0] pick(input logic [4:0] r);
    logic [32:0] res;
    res = {1'b1, (RF_BYPASS != 0 && w_ws_we && w_ws_addr == r) ? w_ws_data : r_rf[r]};
    for (int i = FWD_N - 1; i >= 0; i--)
      if (fwd_valid[i] && fwd_we[i] && fwd_dest[5*i +: 5] == r) res = {fwd_ready[i], fwd_data[32*i +: 32]};
    return (r == 5'd0) ? {1'b1, 32'h0} : res;
  endfunction

  // operand selection, re-evaluated every cycle so a held instruction picks up late results
  always_comb begin
    w_rs_sel = pick(w_rs);
    w_rt_sel = pick(w_rt);
  end

  assign w_rs_val    = w_rs_sel[31:0];
  assign w_rt_val    = w_rt_sel[31:0];
  assign w_ready_go  = !(w_rs_use && !w_rs_sel[32]) && !(w_rt_use && !w_rt_sel[32]);
  assign w_eq        = w_rs_val == w_rt_val;
  assign w_br_taken  = r_ds_valid && w_ready_go && (w_beq && w_eq || w_bne && !w_eq || w_jal || w_jr);
  assign w_br_target = w_jr ? w_rs_val :
                       w_jal ? {w_fs_pc[31:28], w_jidx, 2'b00} :
                       w_fs_pc + {{14{w_imm[15]}}, w_imm, 2'b00};

  assign ds_allowin     = !r_ds_valid || (w_ready_go && es_allowin);
  assign ds_to_es_valid = r_ds_valid && w_ready_go;
  assign ds_to_es_bus   = {w_alu_op, w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm, w_src2_is_8,
                           w_gr_we, w_mem_we, w_dest, w_imm, w_rs_val, w_rt_val, r_pc};
  assign br_bus         = {w_br_taken, w_br_target};
  assign stall_cnt      = r_stall_cnt;

  // register file write from WB; $0 is never written
  always_ff @(posedge clk) begin
    if (w_ws_we && w_ws_addr != 5'd0) r_rf[w_ws_addr] <= w_ws_data;
  end

  // ID valid bit and latched instruction/pc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ds_valid <= 1'b0;
      r_inst     <= 32'h0;
      r_pc       <= 32'h0;
    end else begin
      if (ds_allowin) r_ds_valid <= fs_to_ds_valid;
      if (ds_allowin && fs_to_ds_valid) {r_inst, r_pc} <= fs_to_ds_bus;
    end
  end

  // saturating count of interlock cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_cnt <= '0;
    else if (r_ds_valid && !w_ready_go && r_stall_cnt != {CNT_WD{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_WD'(1);
  end
endmodule
